// File: rtl/clip_pass_sequencer.sv
// Plane-by-plane clip loop scheduler: ping-pongs triangles between two
// external show-ahead buffers through a shared clipper, then drains survivors.
module clip_pass_sequencer #(
   parameter int NUM_PLANES = 6,
   parameter int MAX_TRIS   = 64,
   parameter int CNT_W      = $clog2(MAX_TRIS+1),
   parameter int PL_W       = $clog2(NUM_PLANES)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            tri_valid_i,
   output logic            tri_ready_o,
   output logic [1:0]      wr_src_o,
   output logic            buf_a_wr_o,
   output logic            buf_b_wr_o,
   output logic            buf_a_rd_o,
   output logic            buf_b_rd_o,
   output logic            clip_start_o,
   output logic [PL_W-1:0] clip_plane_o,
   input  logic            clip_done_i,
   input  logic [1:0]      clip_num_tris_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic            out_buf_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            culled_o,
   output logic            overflow_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EMIT0,
      S_EMIT1,
      S_CHECK,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [PL_W-1:0]  LAST_PL = PL_W'(NUM_PLANES-1);
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(MAX_TRIS);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state_q;
   logic [PL_W-1:0]  plane_q;
   logic [CNT_W-1:0] src_cnt_q;
   logic [CNT_W-1:0] dst_cnt_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic             two_q;
   logic             culled_q;
   logic             overflow_q;
   logic             out_buf_q;

   logic src_b;
   logic accept;
   logic emit;
   logic emit_wr;
   logic pop;

   // Odd planes read B and write A; even planes the reverse.
   assign src_b   = plane_q[0];
   assign accept  = (state_q == S_IDLE) & tri_valid_i;
   assign emit    = (state_q == S_EMIT0) | (state_q == S_EMIT1);
   assign emit_wr = emit & (dst_cnt_q != FULL);
   assign pop     = out_valid_o & out_ready_i;

   assign tri_ready_o  = (state_q == S_IDLE);
   assign clip_start_o = (state_q == S_ISSUE);
   assign out_valid_o  = (state_q == S_DRAIN) & (out_cnt_q != '0);
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign culled_o     = done_o & culled_q;
   assign overflow_o   = overflow_q;
   assign clip_plane_o = plane_q;
   assign out_buf_o    = out_buf_q;

   assign buf_a_wr_o = accept | (emit_wr & src_b);
   assign buf_b_wr_o = emit_wr & ~src_b;
   assign buf_a_rd_o = (clip_start_o & ~src_b) | (pop & ~out_buf_q);
   assign buf_b_rd_o = (clip_start_o & src_b) | (pop & out_buf_q);

   always_comb begin
      wr_src_o = 2'b00;
      if (state_q == S_EMIT0) wr_src_o = 2'b01;
      if (state_q == S_EMIT1) wr_src_o = 2'b10;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         plane_q    <= '0;
         src_cnt_q  <= '0;
         dst_cnt_q  <= '0;
         out_cnt_q  <= '0;
         two_q      <= 1'b0;
         culled_q   <= 1'b0;
         overflow_q <= 1'b0;
         out_buf_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (tri_valid_i) begin
                  src_cnt_q  <= ONE;
                  dst_cnt_q  <= '0;
                  plane_q    <= '0;
                  overflow_q <= 1'b0;
                  culled_q   <= 1'b0;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               src_cnt_q <= src_cnt_q - ONE;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (clip_done_i) begin
                  two_q   <= clip_num_tris_i[1];
                  state_q <= (clip_num_tris_i == 2'd0) ? S_CHECK : S_EMIT0;
               end
            end
            S_EMIT0, S_EMIT1: begin
               if (dst_cnt_q == FULL) overflow_q <= 1'b1;
               else dst_cnt_q <= dst_cnt_q + ONE;
               state_q <= (state_q == S_EMIT0 && two_q) ? S_EMIT1 : S_CHECK;
            end
            S_CHECK: begin
               if (src_cnt_q != '0) begin
                  state_q <= S_ISSUE;
               end else if (dst_cnt_q == '0) begin
                  culled_q <= 1'b1;
                  state_q  <= S_DONE;
               end else if (plane_q == LAST_PL) begin
                  out_cnt_q <= dst_cnt_q;
                  out_buf_q <= ~src_b;
                  state_q   <= S_DRAIN;
               end else begin
                  plane_q   <= plane_q + PL_W'(1);
                  src_cnt_q <= dst_cnt_q;
                  dst_cnt_q <= '0;
                  state_q   <= S_ISSUE;
               end
            end
            S_DRAIN: begin
               if (pop) begin
                  out_cnt_q <= out_cnt_q - ONE;
                  if (out_cnt_q == ONE) state_q <= S_DONE;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clip_pass_sequencer.sv
// Randomized bench for clip_pass_sequencer: clipper stub, pass-count
// reference model and drain scoreboard for a 64-deep and a 4-deep instance.
module tb_clip_pass_sequencer;

   localparam int NP = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tv [2];
   logic       tr [2];
   logic [1:0] wsrc [2];
   logic       awr [2];
   logic       bwr [2];
   logic       ard [2];
   logic       brd [2];
   logic       cst [2];
   logic [2:0] cpl [2];
   logic       cdone [2];
   logic [1:0] cnum [2];
   logic       ov [2];
   logic       ordy [2];
   logic       obuf [2];
   logic       busy [2];
   logic       dn [2];
   logic       cul [2];
   logic       ovf [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   clip_pass_sequencer #(.NUM_PLANES(NP), .MAX_TRIS(64)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .tri_valid_i(tv[0]), .tri_ready_o(tr[0]),
      .wr_src_o(wsrc[0]), .buf_a_wr_o(awr[0]), .buf_b_wr_o(bwr[0]),
      .buf_a_rd_o(ard[0]), .buf_b_rd_o(brd[0]), .clip_start_o(cst[0]),
      .clip_plane_o(cpl[0]), .clip_done_i(cdone[0]), .clip_num_tris_i(cnum[0]),
      .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .out_buf_o(obuf[0]),
      .busy_o(busy[0]), .done_o(dn[0]), .culled_o(cul[0]), .overflow_o(ovf[0])
   );

   clip_pass_sequencer #(.NUM_PLANES(NP), .MAX_TRIS(4)) u_small (
      .clk_i(clk), .rst_ni(rst_n), .tri_valid_i(tv[1]), .tri_ready_o(tr[1]),
      .wr_src_o(wsrc[1]), .buf_a_wr_o(awr[1]), .buf_b_wr_o(bwr[1]),
      .buf_a_rd_o(ard[1]), .buf_b_rd_o(brd[1]), .clip_start_o(cst[1]),
      .clip_plane_o(cpl[1]), .clip_done_i(cdone[1]), .clip_num_tris_i(cnum[1]),
      .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .out_buf_o(obuf[1]),
      .busy_o(busy[1]), .done_o(dn[1]), .culled_o(cul[1]), .overflow_o(ovf[1])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int eff(input int n);
      return (n > 2) ? 2 : n;
   endfunction

   // Clipper result policy per test mode, plane and triangle index in pass.
   function automatic int pick_num(input int mode, input int pl, input int idx);
      int r;
      case (mode)
         0: return 1;
         1: return 2;
         2: return (pl == 2) ? 0 : 1;
         3: begin
            if (pl == 0) return 2;
            if (pl == 1) return (idx == 0) ? 3 : 1;
            return 1;
         end
         default: begin
            r = $urandom_range(0, 9);
            if (r == 0) return 0;
            if (r <= 5) return 1;
            if (r <= 7) return 2;
            return 3;
         end
      endcase
   endfunction

   task automatic run_tri(input int d, input int nmode, input int rmode,
                          input int lat_fix, input int rst_plane,
                          output int last_plane, output int last_starts,
                          output int drain_cyc);
      int maxt, exp_plane, exp_left, prod, pass_wr, pidx, sum, cyc;
      int timer, pend, n, lat, pops, last_pop, dcyc, fin_cnt, emit_i;
      bit exp_ovf, drain_seen, fin, rst_arm;
      maxt = (d != 0) ? 4 : 64;
      exp_plane = 0; exp_left = 1; prod = 0; pass_wr = 0; pidx = 0;
      sum = 0; timer = 0; pend = 0; pops = 0; last_pop = -100; dcyc = 0;
      fin_cnt = 0; emit_i = 0; exp_ovf = 0; drain_seen = 0; fin = 0;
      rst_arm = 0; drain_cyc = -1;

      @(negedge clk);
      chk("ready", tr[d], 1);
      tv[d] = 1'b1;
      #1;
      chk("accept_wr", {awr[d], bwr[d], wsrc[d]}, 4'b1000);
      @(negedge clk);
      tv[d] = 1'b0;
      cyc = 1;
      chk("ovf_clear", ovf[d], 0);

      while (!fin && cyc < 20000) begin
         cdone[d] = 1'b0;
         if (timer > 0) begin
            timer--;
            if (timer == 0) begin
               cdone[d] = 1'b1;
               cnum[d] = 2'(pend);
            end
         end
         case (rmode)
            0: ordy[d] = 1'b1;
            1: ordy[d] = drain_seen && dcyc >= 5 && (dcyc % 2 == 1);
            default: ordy[d] = 1'($urandom_range(0, 1));
         endcase
         if (rmode == 1 && drain_seen && dcyc < 5 && timer == 0) begin
            cdone[d] = 1'b1;
            cnum[d] = 2'd2;
         end
         #1;

         if (rst_arm) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy[d], 0);
            chk("rst_strobes", {awr[d], bwr[d], ard[d], brd[d], cst[d], ov[d], dn[d]}, 0);
            cdone[d] = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("rst_no_done", dn[d], 0);
            end
            rst_n = 1'b1;
            fin = 1;
            break;
         end

         if (cst[d]) begin
            if (exp_left == 0) begin
               chk("pass_wr", pass_wr, imin(prod, maxt));
               if (prod > maxt) exp_ovf = 1;
               exp_plane++;
               exp_left = imin(prod, maxt);
               prod = 0; pass_wr = 0; pidx = 0;
            end
            chk("plane", cpl[d], exp_plane);
            chk("src_rd", {ard[d], brd[d]}, (exp_plane % 2) ? 2'b01 : 2'b10);
            n = pick_num(nmode, exp_plane, pidx);
            lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4);
            prod += eff(n);
            sum += 2 + lat + eff(n);
            exp_left--; pidx++;
            timer = lat; pend = n; emit_i = 0;
            if (exp_plane == rst_plane) rst_arm = 1;
         end

         if (awr[d] || bwr[d]) begin
            chk("dst_wr", {awr[d], bwr[d]}, (exp_plane % 2) ? 2'b10 : 2'b01);
            chk("wr_src", wsrc[d], (emit_i == 0) ? 1 : 2);
            emit_i++; pass_wr++;
         end

         if (ov[d] && !drain_seen) begin
            drain_seen = 1;
            drain_cyc = cyc;
            fin_cnt = imin(prod, maxt);
            if (prod > maxt) exp_ovf = 1;
            chk("t_drain", cyc, 1 + sum);
            chk("pass_wr_last", pass_wr, fin_cnt);
            chk("out_buf", obuf[d], ((NP - 1) % 2 == 0) ? 1 : 0);
            chk("busy_ready", {busy[d], tr[d]}, 2'b10);
         end else if (drain_seen) begin
            dcyc++;
         end

         if (drain_seen && !dn[d] && pops < fin_cnt)
            chk("ov_hold", ov[d], 1);

         if (!cst[d] && (ard[d] || brd[d])) begin
            chk("pop_hs", {ov[d], ordy[d]}, 2'b11);
            chk("pop_buf", {ard[d], brd[d]}, obuf[d] ? 2'b01 : 2'b10);
            pops++;
            last_pop = cyc;
         end

         if (dn[d]) begin
            fin = 1;
            if (prod > maxt) exp_ovf = 1;
            chk("culled", cul[d], (prod == 0) ? 1 : 0);
            chk("ovf", ovf[d], exp_ovf);
            if (prod == 0) begin
               chk("t_done_cull", cyc, 1 + sum);
               chk("no_drain", drain_seen, 0);
            end else begin
               chk("pops", pops, fin_cnt);
               chk("t_done", cyc, last_pop + 1);
               chk("npass", exp_plane, NP - 1);
            end
         end

         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end

      if (!fin) chk("timeout", 0, 1);
      cdone[d] = 1'b0;
      ordy[d] = 1'b0;
      @(negedge clk);
      chk("idle_ready", tr[d], 1);
      chk("done_pulse", dn[d], 0);
      last_plane = exp_plane;
      last_starts = pidx;
   endtask

   initial begin
      int lp, ls, dc;
      for (int i = 0; i < 2; i++) begin
         tv[i] = 1'b0; cdone[i] = 1'b0; cnum[i] = 2'd0; ordy[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_ready", tr[0], 1);
      chk("rst_busy0", busy[0], 0);
      chk("rst_outs", {cst[0], ov[0], dn[0], cul[0], ovf[0], obuf[0]}, 0);
      chk("rst_plane", cpl[0], 0);
      rst_n = 1'b1;

      run_tri(0, 0, 0, 3, -1, lp, ls, dc);
      chk("pass_thru_37", dc, 37);
      run_tri(0, 1, 0, 3, -1, lp, ls, dc);
      chk("split_last_starts", ls, 32);
      run_tri(1, 1, 0, 2, -1, lp, ls, dc);
      chk("ovf_sticky", ovf[1], 1);
      run_tri(1, 0, 0, 2, -1, lp, ls, dc);
      chk("ovf_after", ovf[1], 0);
      run_tri(0, 2, 0, 0, -1, lp, ls, dc);
      chk("cull_plane", lp, 2);
      run_tri(0, 3, 1, 0, -1, lp, ls, dc);
      run_tri(0, 0, 0, 3, 3, lp, ls, dc);
      chk("reset_plane", lp, 3);
      run_tri(0, 0, 0, 3, -1, lp, ls, dc);
      chk("post_reset_37", dc, 37);
      repeat (6) run_tri(0, 4, 2, 0, -1, lp, ls, dc);
      repeat (3) run_tri(1, 4, 2, 0, -1, lp, ls, dc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
